// File: rtl/alu_ctrl.sv
// Command/response sequencer in front of a registered ALU: issue, capture flags and result, hand back.
// Optional macro DIV_ZERO_CHECK_EN rejects divide-by-zero commands with an error response.
module alu_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_A,
  input  logic [15:0] CMD_B,
  input  logic [3:0]  CMD_FUN,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [3:0]  ALU_FUN,
  input  logic [15:0] ALU_OUT,
  input  logic        Arith_Flag,
  input  logic        Logic_Flag,
  input  logic        CMP_Flag,
  input  logic        Shift_Flag,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [15:0] RES_DATA,
  output logic [3:0]  RES_CLASS,
  output logic [3:0]  RES_TAG,
  output logic        RES_ERR
);

  localparam logic [3:0] FunNop = 4'b1111;

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e      r_state;
  logic        r_cmd_ready;
  logic        r_res_valid;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [3:0]  r_fun;
  logic [15:0] r_data;
  logic [3:0]  r_class;
  logic [3:0]  r_tag;
  logic [3:0]  r_tag_cnt;

  logic        w_accept;
  logic        w_div_zero;

  assign w_accept = CMD_VALID && r_cmd_ready;

`ifdef DIV_ZERO_CHECK_EN
  logic r_err;

  assign w_div_zero = (CMD_FUN == 4'b0011) && (CMD_B == 16'h0000);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (r_state == StIdle && w_accept) begin
      r_err <= w_div_zero;
    end
  end

  assign RES_ERR = r_err;
`else
  assign w_div_zero = 1'b0;
  assign RES_ERR    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_fun       <= FunNop;
      r_data      <= 16'h0000;
      r_class     <= 4'b0000;
      r_tag       <= 4'h0;
      r_tag_cnt   <= 4'h0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_tag       <= r_tag_cnt;
            r_tag_cnt   <= r_tag_cnt + 4'd1;
            r_cmd_ready <= 1'b0;
            if (w_div_zero) begin
              // Rejected: ALU never sees the command, response is synthesised here.
              r_data      <= 16'hFFFF;
              r_class     <= 4'b1000;
              r_res_valid <= 1'b1;
              r_state     <= StResp;
            end else begin
              r_a     <= CMD_A;
              r_b     <= CMD_B;
              r_fun   <= CMD_FUN;
              r_state <= StIssue;
            end
          end
        end
        StIssue: begin
          r_class <= {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
          r_state <= StCapture;
        end
        StCapture: begin
          // ALU_OUT now reflects the operands presented during the issue cycle.
          r_data      <= ALU_OUT;
          r_fun       <= FunNop;
          r_res_valid <= 1'b1;
          r_state     <= StResp;
        end
        StResp: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_cmd_ready <= 1'b1;
          r_res_valid <= 1'b0;
          r_fun       <= FunNop;
        end
      endcase
    end
  end

  assign CMD_READY = r_cmd_ready;
  assign RES_VALID = r_res_valid;
  assign A         = r_a;
  assign B         = r_b;
  assign ALU_FUN   = r_fun;
  assign RES_DATA  = r_data;
  assign RES_CLASS = r_class;
  assign RES_TAG   = r_tag;

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: behavioural ALU stub plus directed and randomized command sequences.
module tb_alu_ctrl;

  logic        CLK;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [15:0] CMD_A;
  logic [15:0] CMD_B;
  logic [3:0]  CMD_FUN;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        Arith_Flag;
  logic        Logic_Flag;
  logic        CMP_Flag;
  logic        Shift_Flag;
  logic        RES_VALID;
  logic        RES_READY;
  logic [15:0] RES_DATA;
  logic [3:0]  RES_CLASS;
  logic [3:0]  RES_TAG;
  logic        RES_ERR;

  int          checks;
  int          failures;
  int          tag_model;
  logic [15:0] last_a;
  logic [15:0] last_b;

  alu_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_A      (CMD_A),
    .CMD_B      (CMD_B),
    .CMD_FUN    (CMD_FUN),
    .A          (A),
    .B          (B),
    .ALU_FUN    (ALU_FUN),
    .ALU_OUT    (ALU_OUT),
    .Arith_Flag (Arith_Flag),
    .Logic_Flag (Logic_Flag),
    .CMP_Flag   (CMP_Flag),
    .Shift_Flag (Shift_Flag),
    .RES_VALID  (RES_VALID),
    .RES_READY  (RES_READY),
    .RES_DATA   (RES_DATA),
    .RES_CLASS  (RES_CLASS),
    .RES_TAG    (RES_TAG),
    .RES_ERR    (RES_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 16'd0) ? 16'd0 : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~(a & b);
      4'd7:    return ~(a | b);
      4'd8:    return a ^ b;
      4'd9:    return ~(a ^ b);
      4'd10:   return (a == b) ? 16'd1 : 16'd0;
      4'd11:   return (a > b) ? 16'd2 : 16'd0;
      4'd12:   return (a < b) ? 16'd3 : 16'd0;
      4'd13:   return a >> 1;
      4'd14:   return a << 1;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [3:0] class_ref(input logic [3:0] f);
    if (f <= 4'd3)       return 4'b1000;
    else if (f <= 4'd9)  return 4'b0100;
    else if (f <= 4'd12) return 4'b0010;
    else if (f <= 4'd14) return 4'b0001;
    else                 return 4'b0000;
  endfunction

  // ALU stub: registered result, combinational class flags.
  assign {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = class_ref(ALU_FUN);
  always @(posedge CLK) ALU_OUT <= alu_ref(A, B, ALU_FUN);

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_res_valid", RES_VALID, 1'b0);
    check("rst_cmd_ready", CMD_READY, 1'b1);
    check("rst_res_data", RES_DATA, 16'h0);
    check("rst_res_class", RES_CLASS, 4'h0);
    check("rst_res_tag", RES_TAG, 4'h0);
    check("rst_res_err", RES_ERR, 1'b0);
    check("rst_a", A, 16'h0);
    check("rst_b", B, 16'h0);
    check("rst_alu_fun", ALU_FUN, 4'hF);
    tag_model = 0;
    last_a    = 16'h0;
    last_b    = 16'h0;
  endtask

  task automatic apply_reset();
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    RES_READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_reset_values();
  endtask

  // Offer one command from IDLE, follow it to the response, optionally stall RES_READY.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input int stall);
    logic [15:0] exp_data;
    logic [3:0]  exp_class;
    logic        exp_err;
    int          exp_lat;
    int          exp_tag;
    int          lat;
    int          w;
    bit          dz;
`ifdef DIV_ZERO_CHECK_EN
    dz = (f == 4'b0011) && (b == 16'h0);
`else
    dz = 1'b0;
`endif
    exp_data  = dz ? 16'hFFFF : alu_ref(a, b, f);
    exp_class = dz ? 4'b1000 : class_ref(f);
    exp_err   = dz;
    exp_lat   = dz ? 1 : 3;
    exp_tag   = tag_model;

    w = 0;
    while (CMD_READY !== 1'b1 && w < 20) begin
      @(negedge CLK);
      w++;
    end
    check("cmd_ready_idle", CMD_READY, 1'b1);
    CMD_VALID = 1'b1;
    CMD_A     = a;
    CMD_B     = b;
    CMD_FUN   = f;
    RES_READY = (stall == 0);
    @(negedge CLK);
    tag_model = (tag_model + 1) % 16;
    CMD_VALID = 1'b0;
    CMD_A     = 16'($urandom);
    CMD_B     = 16'($urandom);
    CMD_FUN   = 4'($urandom);

    // Latency counts the accept cycle as cycle 0.
    lat = 1;
    while (RES_VALID !== 1'b1 && lat < 8) begin
      check("busy_alu_fun", ALU_FUN, f);
      check("busy_a", A, a);
      check("busy_b", B, b);
      check("busy_cmd_ready", CMD_READY, 1'b0);
      @(negedge CLK);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("resp_data", RES_DATA, exp_data);
    check("resp_class", RES_CLASS, exp_class);
    check("resp_tag", RES_TAG, exp_tag);
    check("resp_err", RES_ERR, exp_err);
    check("resp_alu_fun", ALU_FUN, 4'hF);
    check("resp_cmd_ready", CMD_READY, 1'b0);
    if (dz) begin
      check("dz_a_held", A, last_a);
      check("dz_b_held", B, last_b);
    end else begin
      last_a = a;
      last_b = b;
    end

    for (int i = 0; i < stall; i++) begin
      CMD_VALID = 1'b1;
      CMD_A     = 16'($urandom);
      CMD_B     = 16'($urandom);
      CMD_FUN   = 4'd0;
      @(negedge CLK);
      check("hold_valid", RES_VALID, 1'b1);
      check("hold_data", RES_DATA, exp_data);
      check("hold_class", RES_CLASS, exp_class);
      check("hold_tag", RES_TAG, exp_tag);
      check("hold_err", RES_ERR, exp_err);
      check("hold_cmd_ready", CMD_READY, 1'b0);
    end
    CMD_VALID = 1'b0;
    RES_READY = 1'b1;
    @(negedge CLK);
    check("done_res_valid", RES_VALID, 1'b0);
    check("done_cmd_ready", CMD_READY, 1'b1);
    check("done_alu_fun", ALU_FUN, 4'hF);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  rf;
    checks    = 0;
    failures  = 0;
    tag_model = 0;
    last_a    = 16'h0;
    last_b    = 16'h0;
    CMD_A     = 16'h0;
    CMD_B     = 16'h0;
    CMD_FUN   = 4'h0;
    CMD_VALID = 1'b0;
    RES_READY = 1'b0;
    RST       = 1'b1;

    apply_reset();

    // Add
    run_cmd(16'd100, 16'd23, 4'b0000, 0);

    // Compare pair after a fresh reset
    apply_reset();
    run_cmd(16'd5, 16'd9, 4'b1100, 0);
    run_cmd(16'd5, 16'd9, 4'b1011, 0);

    // XOR with backpressure and a second command offered during the stall
    run_cmd(16'hF0F0, 16'h0FF0, 4'b1000, 5);

    // Tag wrap with back-to-back shift-left
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      run_cmd(16'd1, 16'($urandom), 4'b1110, 0);
    end
    check("wrap_last_tag", RES_TAG, 4'd0);

    // Reset while in CAPTURE
    apply_reset();
    CMD_VALID = 1'b1;
    CMD_A     = 16'd40;
    CMD_B     = 16'd2;
    CMD_FUN   = 4'b0000;
    RES_READY = 1'b1;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_reset_values();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_rst_no_valid", RES_VALID, 1'b0);
    end
    run_cmd(16'd40, 16'd2, 4'b0000, 0);

    // Reset wins over a simultaneous handshake
    CMD_VALID = 1'b1;
    CMD_A     = 16'h1234;
    CMD_B     = 16'h0042;
    CMD_FUN   = 4'b0001;
    RST       = 1'b1;
    @(negedge CLK);
    RST       = 1'b0;
    CMD_VALID = 1'b0;
    check_reset_values();
    run_cmd(16'd9, 16'd4, 4'b0001, 0);

    // Divide by zero, then a normal divide
    run_cmd(16'd7, 16'd0, 4'b0011, 0);
    run_cmd(16'd50, 16'd7, 4'b0011, 1);

    // Opcode 1111 issued as a no-op
    run_cmd(16'hABCD, 16'h1357, 4'b1111, 0);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      rf = 4'($urandom_range(0, 15));
      run_cmd(ra, rb, rf, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 The module SHALL have one clock, CLK, and one reset, RST; RST is synchronous and active-high.
REQ-002 The module SHALL have these ports, clock and reset first:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous active-high reset.
- CMD_VALID  input  1  command offered.
- CMD_READY  output  1  command accepted when high with CMD_VALID.
- CMD_A  input  16  operand A.
- CMD_B  input  16  operand B.
- CMD_FUN  input  4  ALU opcode.
- A  output  16  operand to ALU.
- B  output  16  operand to ALU.
- ALU_FUN  output  4  opcode to ALU.
- ALU_OUT  input  16  ALU result, registered inside the ALU with 1-cycle latency.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  input  1 each  ALU class flags, combinational from ALU_FUN.
- RES_VALID  output  1  result available.
- RES_READY  input  1  result consumed when high with RES_VALID.
- RES_DATA  output  16  captured ALU_OUT.
- RES_CLASS  output  4  {Arith,Logic,CMP,Shift} flags captured for the command.
- RES_TAG  output  4  sequence number of the command.
- RES_ERR  output  1  command rejected, not issued.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, CAPTURE, RESP; reset state IDLE.
REQ-004 CMD_READY SHALL be high only in IDLE; RES_VALID SHALL be high only in RESP.
REQ-005 IDLE: on CMD_VALID&&CMD_READY, CMD_A/CMD_B/CMD_FUN SHALL be registered onto A/B/ALU_FUN and the FSM SHALL go to ISSUE.
REQ-006 ISSUE (one cycle): A/B/ALU_FUN stable; the four flag inputs SHALL be registered into RES_CLASS at the end of this cycle; next state CAPTURE.
REQ-007 CAPTURE (one cycle): ALU_OUT SHALL be registered into RES_DATA at the end of this cycle; next state RESP.
REQ-008 RESP: RES_DATA/RES_CLASS/RES_TAG/RES_ERR SHALL hold stable while RES_VALID&&!RES_READY; on RES_VALID&&RES_READY the FSM SHALL go to IDLE.
REQ-009 Latency SHALL be exactly 3 cycles from the accepting edge to RES_VALID rising; peak throughput one command per 4 cycles with RES_READY held high.
REQ-010 ALU_FUN SHALL be driven to 4'b1111 (ALU no-op, result 0, flags 0) in IDLE and RESP; A/B SHALL hold their last values.
REQ-011 A 4-bit tag counter SHALL increment on every accepted command, wrapping 15->0; RES_TAG SHALL be the counter value before the increment.
REQ-012 Opcode 4'b1111 on CMD_FUN SHALL be issued normally and return RES_DATA=0, RES_CLASS=0.
REQ-013 CMD_VALID outside IDLE SHALL be ignored (no accept, no state change); CMD_* need not be held after acceptance.

Reset
REQ-014 RST SHALL force: state IDLE, CMD_READY=1 next cycle, RES_VALID=0, RES_DATA=0, RES_CLASS=0, RES_TAG=0, RES_ERR=0, A=0, B=0, ALU_FUN=4'b1111, tag counter=0.
REQ-015 RST asserted in any state SHALL abandon the in-flight command with no response produced.
REQ-016 RST SHALL take priority over any simultaneous handshake.

Configuration
REQ-017 With macro DIV_ZERO_CHECK_EN defined, a command with CMD_FUN=4'b0011 and CMD_B=0 SHALL NOT be issued: A/B/ALU_FUN unchanged, FSM goes IDLE->RESP directly (RES_VALID 1 cycle after accept), RES_DATA=16'hFFFF, RES_CLASS=4'b1000, RES_ERR=1, tag consumed normally.
REQ-018 Without DIV_ZERO_CHECK_EN, divide-by-zero SHALL be issued as any other command and RES_ERR SHALL be constant 0.

Verification
REQ-019 Add: A=16'd100, B=16'd23, FUN=0000, RES_READY=1 -> RES_VALID 3 cycles after accept, RES_DATA=123, RES_CLASS=1000, RES_TAG=0.
REQ-020 Compare: A=5, B=9, FUN=1100 then FUN=1011 -> RES_DATA=3 CLASS=0010 TAG=0, then RES_DATA=0 CLASS=0010 TAG=1.
REQ-021 Backpressure: XOR A=16'hF0F0, B=16'h0FF0, RES_READY low 5 cycles -> RES_DATA=16'hFF00 held 5+ cycles, CMD_READY low throughout, second CMD_VALID not accepted.
REQ-022 Tag wrap: 17 back-to-back shift-left commands A=1 -> RES_DATA=2 each, tags 0..15 then 0.
REQ-023 Reset mid-op: accept add, assert RST in CAPTURE -> no RES_VALID, all outputs at REQ-014 values, next command gets RES_TAG=0.
REQ-024 DIV_ZERO_CHECK_EN: A=7, B=0, FUN=0011 -> RES_VALID 1 cycle after accept, RES_DATA=16'hFFFF, RES_ERR=1, ALU_FUN stays 1111; without macro -> issued, RES_ERR=0.
